instruction_fetch_stage: RTL



---
 rtl/instruction_fetch_stage_if.sv | 25 ++
 rtl/instruction_fetch_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory fetch bus: single-outstanding request with req/ready
// acceptance and a separate rvalid/rdata response.
interface instruction_fetch_stage_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// fills the IF/ID register, with a one-entry skid for responses that land during a stall.
module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   instruction_fetch_stage_if.master        imem,
   input  logic                             stall_in,
   input  logic                             branch_taken,
   input  logic [63:0]                      branch_target,
   output logic [63:0]                      if_id_pc,
   output logic [31:0]                      if_id_instruction,
   output logic                             if_id_valid,
   output logic                             fetch_busy
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_e;

   localparam logic [63:0] STEP = 64'(PC_STEP);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_pc_q, req_pc_d;
   logic        discard_q, discard_d;
   logic [63:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [63:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        handshake;

   assign imem.imem_req   = (state_q == S_REQ) && !rst;
   assign imem.imem_addr  = pc_q;
   assign handshake       = imem.imem_req && imem.imem_ready;

   assign fetch_busy        = (state_q == S_WAIT);
   assign if_id_pc          = if_id_pc_q;
   assign if_id_instruction = if_id_instr_q;
   assign if_id_valid       = if_id_valid_q;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      discard_d     = discard_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = stall_in ? if_id_valid_q : 1'b0;

      unique case (state_q)
         S_REQ: begin
            if (handshake) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else if (!stall_in) begin
                  if_id_pc_d    = req_pc_q;
                  if_id_instr_d = imem.imem_rdata;
                  if_id_valid_d = 1'b1;
                  pc_d          = req_pc_q + STEP;
                  state_d       = S_REQ;
               end else begin
                  skid_pc_d    = req_pc_q;
                  skid_instr_d = imem.imem_rdata;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall_in) begin
               if_id_pc_d    = skid_pc_q;
               if_id_instr_d = skid_instr_q;
               if_id_valid_d = 1'b1;
               pc_d          = skid_pc_q + STEP;
               state_d       = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect overrides stall and any delivery; a request already accepted
      // for the old PC must still be drained, so it is marked for discard.
      if (branch_taken) begin
         pc_d          = branch_target & ~64'h3;
         if_id_pc_d    = if_id_pc_q;
         if_id_instr_d = '0;
         if_id_valid_d = 1'b0;
         unique case (state_q)
            S_REQ:  discard_d = handshake;
            S_WAIT: begin
               discard_d = !imem.imem_rvalid;
               state_d   = imem.imem_rvalid ? S_REQ : S_WAIT;
            end
            S_HOLD: state_d = S_REQ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only; every register here is small enough to clear.
      if (rst) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         req_pc_q      <= '0;
         discard_q     <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= '0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= '0;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         discard_q     <= discard_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

endmodule
